// File: rtl/toy_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : toy_mem_responder
//  Description : Dual-port (instruction + data) word memory for the RISC_TOY
//                core, with a fixed-latency pipelined read path and a
//                streaming boot loader that fills memory from address 0.
//  Revision    : 1.0  initial release
// ============================================================================
module toy_mem_responder #(
    parameter int AW     = 8,   // decoded word-address bits, DEPTH = 2**AW
    parameter int RD_LAT = 1    // read latency, 1 or 2
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        IREQ,
    input  logic [29:0] IADDR,
    output logic [31:0] INSTR,
    input  logic        DREQ,
    input  logic        DRW,
    input  logic [29:0] DADDR,
    input  logic [31:0] DWDATA,
    output logic [31:0] DRDATA,
    input  logic        LD_START,
    input  logic        LD_VALID,
    input  logic [31:0] LD_DATA,
    input  logic        LD_LAST,
    output logic        LD_DONE,
    output logic        BUSY,
    output logic        ADDR_ERR
);

    localparam int          DEPTH     = 2**AW;
    localparam logic [AW-1:0] c_PTR_MAX = {AW{1'b1}};

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_LOAD = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_ptr;
    logic            r_err;
    logic            w_ld_we;
    logic            w_ld_ovf;

    logic [31:0]     mem [DEPTH];

    // Address decode for both core ports
    logic            w_run;
    logic [AW-1:0]   w_iidx;
    logic [AW-1:0]   w_didx;
    logic            w_i_oor;
    logic            w_d_oor;
    logic            w_i_rd;
    logic            w_d_rd;
    logic            w_d_wr;
    logic [31:0]     w_i_data;
    logic [31:0]     w_d_data;

    assign w_run    = (r_state == S_RUN);
    assign w_iidx   = IADDR[AW-1:0];
    assign w_didx   = DADDR[AW-1:0];
    assign w_i_oor  = (IADDR[29:AW] != '0);
    assign w_d_oor  = (DADDR[29:AW] != '0);
    assign w_i_rd   = w_run & IREQ;
    assign w_d_rd   = w_run & DREQ & ~DRW;
    assign w_d_wr   = w_run & DREQ & DRW;
    // Out-of-range reads return zero; the array read sees pre-edge contents,
    // which gives read-before-write against a same-cycle write.
    assign w_i_data = w_i_oor ? 32'h0 : mem[w_iidx];
    assign w_d_data = w_d_oor ? 32'h0 : mem[w_didx];

    // Single write port shared by loader (only in LOAD) and data port (only in RUN)
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [31:0]     w_wdata;

    assign w_we    = w_ld_we | (w_d_wr & ~w_d_oor);
    assign w_waddr = w_ld_we ? r_ptr   : w_didx;
    assign w_wdata = w_ld_we ? LD_DATA : DWDATA;

    assign BUSY     = (r_state == S_LOAD);
    assign LD_DONE  = (r_state == S_FIN);
    assign ADDR_ERR = r_err;

    // FSM state register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) r_state <= S_RUN;
        else       r_state <= w_state_nxt;
    end

    // FSM next state and loader write/overflow decode
    always_comb begin
        w_state_nxt = r_state;
        w_ld_we     = 1'b0;
        w_ld_ovf    = 1'b0;
        case (r_state)
            S_RUN: begin
                if (LD_START) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (LD_VALID) begin
                    w_ld_we = 1'b1;
                    if (LD_LAST || (r_ptr == c_PTR_MAX)) w_state_nxt = S_FIN;
                    if (!LD_LAST && (r_ptr == c_PTR_MAX)) w_ld_ovf = 1'b1;
                end
            end
            S_FIN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Load pointer: cleared on entry to LOAD, advances per accepted boot word
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)                            r_ptr <= '0;
        else if (w_run && LD_START)           r_ptr <= '0;
        else if (w_ld_we)                     r_ptr <= r_ptr + AW'(1);
    end

    // Error pulse: one cycle after a bad core access, or with FIN on loader overflow
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) r_err <= 1'b0;
        else       r_err <= (w_i_rd & w_i_oor) | (w_run & DREQ & w_d_oor) | w_ld_ovf;
    end

    // Memory array write; contents deliberately survive reset
    always_ff @(posedge CLK) begin
        if (w_we) mem[w_waddr] <= w_wdata;
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic        r_i_v1;
            logic        r_d_v1;
            logic [31:0] r_i_d1;
            logic [31:0] r_d_d1;

            // First read stage: capture array data and request valid
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    r_i_v1 <= 1'b0;
                    r_d_v1 <= 1'b0;
                    r_i_d1 <= 32'h0;
                    r_d_d1 <= 32'h0;
                end else begin
                    r_i_v1 <= w_i_rd;
                    r_d_v1 <= w_d_rd;
                    r_i_d1 <= w_i_data;
                    r_d_d1 <= w_d_data;
                end
            end

            // Output stage: update only when a read completes, otherwise hold
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    INSTR  <= 32'h0;
                    DRDATA <= 32'h0;
                end else begin
                    if (r_i_v1) INSTR  <= r_i_d1;
                    if (r_d_v1) DRDATA <= r_d_d1;
                end
            end
        end else begin : g_lat1
            // Single stage: output updates only when a read completes, otherwise hold
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    INSTR  <= 32'h0;
                    DRDATA <= 32'h0;
                end else begin
                    if (w_i_rd) INSTR  <= w_i_data;
                    if (w_d_rd) DRDATA <= w_d_data;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_toy_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_toy_mem_responder
//  Description : Directed self-checking bench for toy_mem_responder
//                (AW=8, RD_LAT=1).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_toy_mem_responder;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        IREQ;
    logic [29:0] IADDR;
    logic [31:0] INSTR;
    logic        DREQ;
    logic        DRW;
    logic [29:0] DADDR;
    logic [31:0] DWDATA;
    logic [31:0] DRDATA;
    logic        LD_START;
    logic        LD_VALID;
    logic [31:0] LD_DATA;
    logic        LD_LAST;
    logic        LD_DONE;
    logic        BUSY;
    logic        ADDR_ERR;

    int n_cmp = 0;
    int n_bad = 0;

    toy_mem_responder #(.AW(8), .RD_LAT(1)) u_dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .IREQ     (IREQ),
        .IADDR    (IADDR),
        .INSTR    (INSTR),
        .DREQ     (DREQ),
        .DRW      (DRW),
        .DADDR    (DADDR),
        .DWDATA   (DWDATA),
        .DRDATA   (DRDATA),
        .LD_START (LD_START),
        .LD_VALID (LD_VALID),
        .LD_DATA  (LD_DATA),
        .LD_LAST  (LD_LAST),
        .LD_DONE  (LD_DONE),
        .BUSY     (BUSY),
        .ADDR_ERR (ADDR_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 unit after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ireq(input logic [29:0] a, input logic [31:0] exp, input string tag);
        IREQ  = 1'b1;
        IADDR = a;
        tick();
        IREQ  = 1'b0;
        chk(tag, INSTR, exp);
    endtask

    initial begin
        logic [31:0] words [4];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;

        RSTN = 1'b0; IREQ = 1'b0; IADDR = '0; DREQ = 1'b0; DRW = 1'b0; DADDR = '0;
        DWDATA = '0; LD_START = 1'b0; LD_VALID = 1'b0; LD_DATA = '0; LD_LAST = 1'b0;
        tick(); tick();
        chk("rst_instr",  INSTR,    32'h0);
        chk("rst_drdata", DRDATA,   32'h0);
        chk("rst_done",   {31'b0, LD_DONE},  32'h0);
        chk("rst_busy",   {31'b0, BUSY},     32'h0);
        chk("rst_err",    {31'b0, ADDR_ERR}, 32'h0);
        RSTN = 1'b1;
        tick();

        // 1: boot load of four words
        LD_START = 1'b1;
        tick();
        LD_START = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t1_busy%0d", k), {31'b0, BUSY}, 32'h1);
            chk($sformatf("t1_done%0d", k), {31'b0, LD_DONE}, 32'h0);
            LD_VALID = 1'b1;
            LD_DATA  = words[k];
            LD_LAST  = (k == 3);
            tick();
        end
        LD_VALID = 1'b0; LD_LAST = 1'b0;
        chk("t1_fin_done", {31'b0, LD_DONE}, 32'h1);
        chk("t1_fin_busy", {31'b0, BUSY},    32'h0);
        tick();
        chk("t1_done_off", {31'b0, LD_DONE}, 32'h0);
        for (int k = 0; k < 4; k++) ireq(30'(k), words[k], $sformatf("t1_rd%0d", k));

        // 2: data write then read of address 5; a write leaves DRDATA alone
        DREQ = 1'b1; DRW = 1'b1; DADDR = 30'd5; DWDATA = 32'hDEADBEEF;
        tick();
        chk("t2_wr_hold", DRDATA, 32'h0);
        DRW = 1'b0;
        tick();
        DREQ = 1'b0;
        chk("t2_rd", DRDATA, 32'hDEADBEEF);

        // 3: read-before-write on address 7, seeded with 0x1
        DREQ = 1'b1; DRW = 1'b1; DADDR = 30'd7; DWDATA = 32'h1;
        tick();
        DWDATA = 32'hA5A5A5A5;
        IREQ = 1'b1; IADDR = 30'd7;
        tick();
        DREQ = 1'b0; DRW = 1'b0;
        chk("t3_old", INSTR, 32'h1);
        ireq(30'd7, 32'hA5A5A5A5, "t3_new");

        // 4: out-of-range read and write at 0x100
        DREQ = 1'b1; DRW = 1'b0; DADDR = 30'h100;
        tick();
        chk("t4_rd0",  DRDATA, 32'h0);
        chk("t4_err1", {31'b0, ADDR_ERR}, 32'h1);
        DRW = 1'b1; DWDATA = 32'h0BAD0BAD;
        tick();
        DREQ = 1'b0; DRW = 1'b0;
        chk("t4_err2", {31'b0, ADDR_ERR}, 32'h1);
        tick();
        chk("t4_err_off", {31'b0, ADDR_ERR}, 32'h0);
        ireq(30'd0, 32'h11, "t4_mem0");
        // both ports out of range together: single pulse
        IREQ = 1'b1; IADDR = 30'h100; DREQ = 1'b1; DRW = 1'b0; DADDR = 30'h200;
        tick();
        IREQ = 1'b0; DREQ = 1'b0;
        chk("t4_both_err", {31'b0, ADDR_ERR}, 32'h1);
        chk("t4_both_ins", INSTR, 32'h0);
        tick();
        chk("t4_both_off", {31'b0, ADDR_ERR}, 32'h0);

        // 5: overflow load of DEPTH+1 words without LD_LAST
        LD_START = 1'b1;
        tick();
        LD_START = 1'b0;
        LD_VALID = 1'b1;
        for (int k = 0; k < 256; k++) begin
            LD_DATA = 32'h1000 + 32'(k);
            tick();
            if (k == 254) chk("t5_err_early", {31'b0, ADDR_ERR}, 32'h0);
        end
        chk("t5_err",  {31'b0, ADDR_ERR}, 32'h1);
        chk("t5_done", {31'b0, LD_DONE},  32'h1);
        chk("t5_busy", {31'b0, BUSY},     32'h0);
        LD_DATA = 32'hFFFF0000;
        tick();
        LD_VALID = 1'b0;
        chk("t5_err_off",  {31'b0, ADDR_ERR}, 32'h0);
        chk("t5_done_off", {31'b0, LD_DONE},  32'h0);
        ireq(30'd0,   32'h1000, "t5_mem0");
        ireq(30'd255, 32'h10FF, "t5_mem255");
        ireq(30'd9,   32'h1009, "t5_mem9");

        // 6: reset in the middle of a load; core write during load is dropped
        LD_START = 1'b1;
        tick();
        LD_START = 1'b0;
        LD_VALID = 1'b1; LD_DATA = 32'hAA;
        tick();
        LD_DATA = 32'hBB;
        DREQ = 1'b1; DRW = 1'b1; DADDR = 30'd9; DWDATA = 32'hFFFFFFFF;
        tick();
        DREQ = 1'b0; DRW = 1'b0; LD_VALID = 1'b0;
        chk("t6_busy_pre", {31'b0, BUSY}, 32'h1);
        RSTN = 1'b0;
        #1;
        chk("t6_busy_rst", {31'b0, BUSY},    32'h0);
        chk("t6_done_rst", {31'b0, LD_DONE}, 32'h0);
        chk("t6_instr_rst", INSTR, 32'h0);
        tick();
        RSTN = 1'b1;
        tick();
        chk("t6_done_after", {31'b0, LD_DONE}, 32'h0);
        chk("t6_busy_after", {31'b0, BUSY},    32'h0);
        ireq(30'd0, 32'hAA,   "t6_mem0");
        ireq(30'd1, 32'hBB,   "t6_mem1");
        ireq(30'd2, 32'h1002, "t6_mem2");
        ireq(30'd9, 32'h1009, "t6_mem9");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
